// File: rtl/rca_seq_adder.sv
// rca_seq_adder
//
// Sequential wide adder built around a single 4-bit carry-chain slice.
// One nibble is added per clock, least-significant nibble first, with the
// carry between nibbles held in a flop. A WIDTH-bit add therefore takes
// NSLICE = WIDTH/4 clocks after the start-sampling edge.
//
// Optional feature macro: SEQ_ADD_SUB_EN
//   When defined, a 'sub' input exists. With sub=1 the block computes a - b
//   as a + ~b + 1 (cin ignored); cout=1 then means "no borrow".
//   When undefined, the block is add-only.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   sub       subtract select (only with SEQ_ADD_SUB_EN)
//   a, b      WIDTH-bit operands, latched on an accepted start
//   cin       carry into nibble 0
//   busy      high while nibbles are being processed
//   done      one-cycle pulse, result valid
//   sum       registered result, held until the next accepted start
//   cout      carry out of the most-significant nibble
//   overflow  two's-complement overflow of the full-width add

module rca_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   // Reject widths the nibble slicing cannot represent.
   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
         $error("rca_seq_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              carry;
   logic [IDXW-1:0]   idx;
   logic [3:0]        nib_a;
   logic [3:0]        nib_b;
   logic [4:0]        slice;
   logic              accept;
   logic              last;
   logic              sub_eff;

   // Effective subtract select; tied off in the add-only build so both
   // builds share one datapath.
   always_comb begin
`ifdef SEQ_ADD_SUB_EN
      sub_eff = sub;
`else
      sub_eff = 1'b0;
`endif
   end

   // The 4-bit slice: pick the current nibble of each latched operand and
   // add it with the held carry. Bit 4 of the result is the nibble carry.
   always_comb begin
      nib_a  = a_r[4*idx +: 4];
      nib_b  = b_r[4*idx +: 4];
      slice  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
      accept = (state == IDLE) && start;
      last   = (state == RUN) && (idx == LAST_IDX);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: leave IDLE on an accepted start, return after the
   // last nibble. Starts seen while running are simply not looked at.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   // Datapath: latch operands on accept, then write one sum nibble per
   // clock. The final nibble also produces cout, overflow and the done
   // pulse. In subtract mode b is inverted at latch time and the initial
   // carry forced to 1, so the overflow formula naturally sees ~b.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_r      <= a;
            b_r      <= sub_eff ? ~b : b;
            carry    <= sub_eff ? 1'b1 : cin;
            idx      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
         end else if (state == RUN) begin
            sum[4*idx +: 4] <= slice[3:0];
            carry           <= slice[4];
            idx             <= idx + 1'b1;
            if (last) begin
               cout     <= slice[4];
               overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (slice[3] != a_r[WIDTH-1]);
               done     <= 1'b1;
               idx      <= '0;
            end
         end
      end
   end

endmodule
